// File: rtl/npu_mac_sequencer.sv
// Sequential fully-connected layer: loads an N_IN feature vector, then computes
// N_OUT neurons with one multiply-accumulate per cycle and streams the Q8.8 results.
module npu_mac_sequencer #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 12,
  parameter int FRAC  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_IN*N_OUT*16-1:0]  weights_flat,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               in_data,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_data,
  output logic [3:0]                out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  // Handshakes: a beat moves on the rising edge where valid and ready are both
  // high; valid and its payload stay stable until that edge.
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int NW = N_IN * N_OUT;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]      cnt;
  logic [IW-1:0]      i;
  logic [3:0]         j;
  logic [KW-1:0]      wk;
  logic signed [15:0] x [N_IN];
  logic signed [15:0] w_mem [NW];
  logic signed [39:0] acc;
  logic               relu_q;

  logic               in_fire, out_fire;
  logic               last_in, last_i, last_j;
  logic signed [15:0] w_cur;
  logic signed [31:0] prod;
  logic signed [39:0] sum;
  logic signed [39:0] shifted;
  logic [15:0]        res;

  for (genvar g = 0; g < NW; g++) begin : g_wsplit
    assign w_mem[g] = weights_flat[16*g +: 16];
  end

  assign in_ready  = reset & (state == LOAD);
  assign busy      = (state == COMPUTE) || (state == EMIT);
  assign state_dbg = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_in   = (cnt == IW'(N_IN - 1));
  assign last_i    = (i == IW'(N_IN - 1));
  assign last_j    = (j == 4'(N_OUT - 1));

  // wk walks k = j*N_IN + i in lockstep with the COMPUTE cycles.
  assign w_cur   = w_mem[wk];
  assign prod    = w_cur * x[i];
  assign sum     = acc + {{8{prod[31]}}, prod};
  assign shifted = sum >>> FRAC;

  always_comb begin
    if (shifted > 40'sd32767)
      res = 16'h7FFF;
    else if (shifted < -40'sd32768)
      res = 16'h8000;
    else
      res = shifted[15:0];
    if (relu_q && res[15])
      res = 16'h0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= LOAD;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_fire && last_in) state_nx = COMPUTE;
      COMPUTE: if (last_i) state_nx = EMIT;
      EMIT:    if (out_fire) state_nx = last_j ? LOAD : COMPUTE;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      i         <= '0;
      j         <= '0;
      wk        <= '0;
      acc       <= '0;
      relu_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      for (int n = 0; n < N_IN; n++) x[n] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            x[cnt] <= in_data;
            if (last_in) begin
              cnt    <= '0;
              i      <= '0;
              j      <= '0;
              wk     <= '0;
              acc    <= '0;
              relu_q <= relu_en;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          wk <= (last_i && last_j) ? '0 : wk + 1'b1;
          if (last_i) begin
            out_data  <= res;
            out_valid <= 1'b1;
            out_idx   <= j;
            out_last  <= last_j;
            i         <= '0;
            acc       <= '0;
          end else begin
            i   <= i + 1'b1;
            acc <= sum;
          end
        end
        EMIT: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            if (last_j) begin
              j   <= '0;
              cnt <= '0;
            end else begin
              j <= j + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_mac_sequencer.sv
// Directed bench for npu_mac_sequencer: table of uniform weight/feature vectors
// plus hand-written latency, backpressure, reset and back-to-back sequences.
module tb_npu_mac_sequencer;

  localparam int N_IN  = 16;
  localparam int N_OUT = 12;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [N_IN*N_OUT*16-1:0] weights_flat;
  logic                     in_valid, in_ready;
  logic [15:0]              in_data;
  logic                     relu_en;
  logic                     out_valid, out_ready;
  logic [15:0]              out_data;
  logic [3:0]               out_idx;
  logic                     out_last;
  logic                     busy;
  logic [1:0]               state_dbg;

  npu_mac_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAC(8)) dut (
    .clk(clk), .reset(reset), .weights_flat(weights_flat),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] w_arr [N_IN*N_OUT];
  always_comb begin
    weights_flat = '0;
    for (int k = 0; k < N_IN*N_OUT; k++) weights_flat[16*k +: 16] = w_arr[k];
  end

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] x_vec [N_IN];
  int          acc_edge_first, acc_edge_last, last_hs_edge, first_valid_edge;
  int          b2b_hs;

  typedef struct {
    logic [15:0] w;
    logic [15:0] x;
    logic        relu;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_w_uniform(input logic [15:0] v);
    for (int k = 0; k < N_IN*N_OUT; k++) w_arr[k] = v;
  endtask

  task automatic set_w_diag();
    for (int jj = 0; jj < N_OUT; jj++)
      for (int ii = 0; ii < N_IN; ii++)
        w_arr[jj*N_IN + ii] = (ii == jj) ? 16'h0100 : 16'h0000;
  endtask

  task automatic send_vec(input int nb, input logic rl);
    for (int f = 0; f < nb; f++) begin
      int b = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = x_vec[f];
      relu_en  = rl;
      while (!in_ready && b < 400) begin
        @(negedge clk);
        b++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        return;
      end
      if (f == 0) acc_edge_first = cyc + 1;
      if (f == nb - 1) acc_edge_last = cyc + 1;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    relu_en  = ~rl;
  endtask

  task automatic recv(input int n, input int stall_k, input int stall_n, input bit period_chk);
    int          prev;
    logic [15:0] e;
    prev = 0;
    for (int k = 0; k < n; k++) begin
      int b = 0;
      @(negedge clk);
      while (!out_valid && b < 100) begin
        @(negedge clk);
        b++;
      end
      chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      if (!out_valid) return;
      if (k == 0) first_valid_edge = cyc;
      else if (period_chk) chk("out_period", cyc - prev, 32'd17);
      prev = cyc;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
      chk("out_data", {16'd0, out_data}, {16'd0, e});
      chk("out_idx", {28'd0, out_idx}, k);
      chk("out_last", {31'd0, out_last}, {31'd0, (k == n - 1)});
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_data", {16'd0, out_data}, {16'd0, e});
          chk("stall_idx", {28'd0, out_idx}, k);
          chk("stall_state", {30'd0, state_dbg}, 32'd2);
        end
        out_ready = 1'b1;
      end
      last_hs_edge = cyc + 1;
    end
  endtask

  initial begin
    tbl[0] = '{16'h0100, 16'h0100, 1'b0, 16'h1000};
    tbl[1] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF};
    tbl[2] = '{16'h8000, 16'h7FFF, 1'b0, 16'h8000};
    tbl[3] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000};
    tbl[4] = '{16'hFF00, 16'h0100, 1'b0, 16'hF000};
    tbl[5] = '{16'hFF00, 16'h0100, 1'b1, 16'h0000};
    tbl[6] = '{16'h0080, 16'h0001, 1'b0, 16'h0008};
    tbl[7] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF};
    tbl[8] = '{16'h0100, 16'h07FF, 1'b0, 16'h7FF0};

    in_valid = 1'b0; in_data = '0; relu_en = 1'b0; out_ready = 1'b1;
    set_w_uniform(16'h0000);

    // reset state
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // table-driven uniform vectors
    for (int t = 0; t < 9; t++) begin
      set_w_uniform(tbl[t].w);
      for (int f = 0; f < N_IN; f++) x_vec[f] = tbl[t].x;
      repeat (N_OUT) exp_q.push_back(tbl[t].exp);
      send_vec(N_IN, tbl[t].relu);
      recv(N_OUT, -1, 0, (t == 0));
      chk("latency", first_valid_edge - acc_edge_last, 32'd16);
    end

    // identity weights: out j = x[j]
    set_w_diag();
    for (int f = 0; f < N_IN; f++) x_vec[f] = 16'(f << 8);
    for (int jj = 0; jj < N_OUT; jj++) exp_q.push_back(16'(jj << 8));
    send_vec(N_IN, 1'b0);
    recv(N_OUT, -1, 0, 1'b1);

    // backpressure at idx 3 with stray in_valid pulses while busy
    for (int jj = 0; jj < N_OUT; jj++) exp_q.push_back(16'(jj << 8));
    send_vec(N_IN, 1'b0);
    fork
      recv(N_OUT, 3, 5, 1'b0);
      begin
        repeat (40) begin
          @(negedge clk);
          in_valid = 1'($urandom_range(0, 1));
          in_data  = 16'h7FFF;
        end
        in_valid = 1'b0;
      end
    join
    for (int jj = 0; jj < N_OUT; jj++) exp_q.push_back(16'(jj << 8));
    send_vec(N_IN, 1'b0);
    recv(N_OUT, -1, 0, 1'b1);

    // back-to-back vectors, second one presented continuously
    set_w_uniform(16'h0100);
    for (int f = 0; f < N_IN; f++) x_vec[f] = 16'h0100;
    repeat (N_OUT) exp_q.push_back(16'h1000);
    repeat (N_OUT) exp_q.push_back(16'h2000);
    send_vec(N_IN, 1'b0);
    fork
      begin
        recv(N_OUT, -1, 0, 1'b1);
        b2b_hs = last_hs_edge;
        recv(N_OUT, -1, 0, 1'b1);
      end
      begin
        for (int f = 0; f < N_IN; f++) x_vec[f] = 16'h0200;
        send_vec(N_IN, 1'b0);
      end
    join
    chk("b2b_accept", acc_edge_first, b2b_hs + 1);
    chk("b2b_latency", first_valid_edge - acc_edge_last, 32'd16);

    // reset mid-COMPUTE
    for (int f = 0; f < N_IN; f++) x_vec[f] = 16'h0100;
    send_vec(N_IN, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rel_busy", {31'd0, busy}, 32'd0);

    // reset while an output is held in EMIT
    send_vec(N_IN, 1'b0);
    out_ready = 1'b0;
    begin
      int b = 0;
      @(negedge clk);
      while (!out_valid && b < 100) begin
        @(negedge clk);
        b++;
      end
    end
    chk("emit_valid", {31'd0, out_valid}, 32'd1);
    chk("emit_data", {16'd0, out_data}, 32'h1000);
    reset = 1'b0;
    #1;
    chk("emit_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("emit_rst_data", {16'd0, out_data}, 32'd0);
    chk("emit_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;

    // reset during a partial load, then a clean vector must start at feature 0
    for (int f = 0; f < N_IN; f++) x_vec[f] = 16'h7FFF;
    send_vec(8, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int f = 0; f < N_IN; f++) x_vec[f] = 16'h0100;
    repeat (N_OUT) exp_q.push_back(16'h1000);
    send_vec(N_IN, 1'b0);
    recv(N_OUT, -1, 0, 1'b1);
    chk("partial_latency", first_valid_edge - acc_edge_last, 32'd16);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npu_mac_sequencer.md
NPU_MAC_SEQUENCER -- requirements
Module: npu_mac_sequencer

Interface
REQ-001 SHALL have parameter N_IN, default 16, meaning input features per vector.
REQ-002 SHALL have parameter N_OUT, default 12, meaning neurons computed per vector (N_IN*N_OUT = 192 weights).
REQ-003 SHALL have parameter FRAC, default 8, meaning fractional bits of the signed Q8.8 format.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006 SHALL have port weights_flat, input, 3072, weight k = j*N_IN+i at bits [16k+15:16k], driven by the registered 192-entry weight ROM outputs.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 16), one signed feature per beat, features 0..N_IN-1 in order.
REQ-008 SHALL have port relu_en, input, 1, enabling ReLU clamp on results.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 16), the signed Q8.8 neuron result.
REQ-010 SHALL have port out_idx, output, 4, neuron index j of out_data.
REQ-011 SHALL have port out_last, output, 1, high with out_valid when out_idx = N_OUT-1.
REQ-012 SHALL have port busy, output, 1, high in COMPUTE or EMIT.

Function
REQ-013 SHALL implement FSM LOAD -> COMPUTE -> EMIT -> (COMPUTE for next neuron | LOAD after neuron N_OUT-1).
REQ-014 in_ready SHALL equal (state==LOAD); a beat transfers on in_valid&in_ready and is written to feature buffer x[cnt], cnt incrementing 0..N_IN-1.
REQ-015 On the transfer of feature N_IN-1: SHALL enter COMPUTE with j=0, i=0, accumulator cleared, relu_en latched for the whole vector.
REQ-016 COMPUTE SHALL add sign-extended w[j][i]*x[i] (32-bit signed product) to a 40-bit signed accumulator each cycle, i=0..N_IN-1, exactly N_IN cycles per neuron.
REQ-017 On the COMPUTE cycle with i=N_IN-1: SHALL register out_data = saturate16(final_sum >>> FRAC), arithmetic shift, truncation toward minus infinity, clamp to [0x8000,0x7FFF], then 0x0000 if the latched relu_en=1 and the result is negative; SHALL set out_valid=1, out_idx=j and enter EMIT.
REQ-018 Latency: out_valid for neuron 0 SHALL rise on the 16th rising edge after the edge accepting feature N_IN-1.
REQ-019 In EMIT, out_data/out_idx/out_last SHALL hold stable until out_valid&out_ready; on the handshake edge out_valid SHALL drop and the FSM SHALL go to COMPUTE (j+1, accumulator cleared) or to LOAD (cnt=0) if j=N_OUT-1.
REQ-020 With out_ready held high, EMIT SHALL last exactly one cycle; the full vector SHALL finish in N_OUT*(N_IN+1) cycles after the last input.
REQ-021 in_valid outside LOAD SHALL be ignored and not stored.
REQ-022 weights_flat SHALL be sampled combinationally each COMPUTE cycle; it is required to be stable while busy=1.
REQ-023 Counters SHALL never wrap past N_IN-1 or N_OUT-1; the FSM SHALL return to LOAD, and a new vector may transfer on the cycle after the last output handshake.

Reset
REQ-024 While reset=0: state=LOAD, cnt=i=j=0, accumulator=0, x buffer=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, in_ready=0.
REQ-025 Reset asserted mid-vector or mid-compute SHALL discard all partial inputs and results; after release in_ready=1 and the next vector SHALL start at feature 0.

Verification
REQ-026 Reset: pulse reset=0 mid-COMPUTE -> all outputs 0 immediately; after release in_ready=1, busy=0.
REQ-027 All weights 0x0100, all features 0x0100, out_ready=1 -> 12 outputs of 0x1000, out_idx 0..11, out_last only on idx 11, one output every 17 cycles.
REQ-028 Weights w[j][i]=0x0100 if i==j else 0, x[i]=i*0x0100 -> out j = j*0x0100 (0x0000..0x0B00).
REQ-029 Saturation: all weights 0x7FFF, features 0x7FFF -> 0x7FFF; weights 0x8000, features 0x7FFF -> 0x8000 with relu_en=0, 0x0000 with relu_en=1.
REQ-030 Backpressure: out_ready=0 for 5 cycles at idx 3 -> out_valid held, out_data/out_idx unchanged, no idx-4 computation until handshake; in_valid pulses during busy ignored.
REQ-031 Back-to-back: second vector presented with in_valid=1 continuously -> first beat accepted on the cycle after the idx-11 handshake; results correct for both vectors.
